// File: rtl/multi_channel_scoreboard.sv
// In-line scoreboard for the shared linked-list FIFO.
// Tracks one magic packet per channel plus a global occupancy model.
module multi_channel_scoreboard #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int NUM_FIFOS = 2,
    parameter int REARM     = 0,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [SEL_WIDTH-1:0] push_sel,
    input  logic [SEL_WIDTH-1:0] pop_sel,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    input  logic                 start,
    output logic [NUM_FIFOS-1:0] armed,
    output logic [NUM_FIFOS-1:0] done,
    output logic                 data_out_vld,
    output logic                 prop_signal,
    output logic                 mismatch,
    output logic                 proto_err
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0]    count [NUM_FIFOS];
    logic [CW-1:0]    ahead [NUM_FIFOS];
    logic [WIDTH-1:0] magic [NUM_FIFOS];
    logic [CW-1:0]    total;

    logic [NUM_FIFOS-1:0] push_c;
    logic [NUM_FIFOS-1:0] pop_c;
    logic [NUM_FIFOS-1:0] pop_ok;
    logic [NUM_FIFOS-1:0] cap;
    logic [NUM_FIFOS-1:0] exit_c;
    logic                 push_full;
    logic                 bad_sel;
    logic                 pop_empty;
    logic [WIDTH-1:0]     magic_sel;

    // Decode channel events; a push into a full model is dropped.
    always_comb begin
        push_c    = '0;
        pop_c     = '0;
        pop_ok    = '0;
        cap       = '0;
        exit_c    = '0;
        pop_empty = 1'b0;
        magic_sel = '0;
        push_full = push & (total == FULL) & ~pop;
        bad_sel   = (push & (int'(push_sel) >= NUM_FIFOS))
                  | (pop & (int'(pop_sel) >= NUM_FIFOS));
        for (int c = 0; c < NUM_FIFOS; c++) begin
            push_c[c] = push & ~push_full & (push_sel == SEL_WIDTH'(c));
            pop_c[c]  = pop & (pop_sel == SEL_WIDTH'(c));
            pop_ok[c] = pop_c[c] & (count[c] != '0);
            if (pop_c[c] && count[c] == '0)
                pop_empty = 1'b1;
            cap[c]    = start & push_c[c] & ~armed[c]
                      & (~done[c] | (REARM != 0));
            exit_c[c] = armed[c] & pop_c[c] & (ahead[c] == '0);
            if (pop_c[c])
                magic_sel = magic[c];
        end
        data_out_vld = |exit_c;
        prop_signal  = ~data_out_vld | (data_out == magic_sel);
    end

    // Occupancy model, per-channel trackers and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total     <= '0;
            armed     <= '0;
            done      <= '0;
            mismatch  <= 1'b0;
            proto_err <= 1'b0;
            for (int c = 0; c < NUM_FIFOS; c++) begin
                count[c] <= '0;
                ahead[c] <= '0;
                magic[c] <= '0;
            end
        end else begin
            if (|push_c && !(|pop_ok))
                total <= total + ONE;
            else if (!(|push_c) && |pop_ok)
                total <= total - ONE;
            if (!prop_signal)
                mismatch <= 1'b1;
            if (push_full || bad_sel || pop_empty)
                proto_err <= 1'b1;
            for (int c = 0; c < NUM_FIFOS; c++) begin
                if (push_c[c] && !pop_ok[c])
                    count[c] <= count[c] + ONE;
                else if (!push_c[c] && pop_ok[c])
                    count[c] <= count[c] - ONE;
                if (exit_c[c]) begin
                    armed[c] <= 1'b0;
                    done[c]  <= 1'b1;
                end else if (cap[c]) begin
                    armed[c] <= 1'b1;
                    done[c]  <= 1'b0;
                    magic[c] <= data_in;
                    ahead[c] <= count[c] - (pop_ok[c] ? ONE : '0);
                end else if (armed[c] && pop_c[c]) begin
                    ahead[c] <= ahead[c] - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Scoreboard bench for multi_channel_scoreboard.
// Two instances: REARM=0 (main) and REARM=1.
module tb_multi_channel_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [0:0] push_sel = '0;
    logic [0:0] pop_sel = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out = '0;
    logic       start = 1'b0;

    logic [1:0] armed0, done0, armed1, done1;
    logic       vld0, prop0, mis0, perr0;
    logic       vld1, prop1, mis1, perr1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic  prop;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    multi_channel_scoreboard #(
        .WIDTH(8), .DEPTH(4), .NUM_FIFOS(2), .REARM(0)
    ) d0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .push_sel(push_sel), .pop_sel(pop_sel),
        .data_in(data_in), .data_out(data_out), .start(start),
        .armed(armed0), .done(done0), .data_out_vld(vld0),
        .prop_signal(prop0), .mismatch(mis0), .proto_err(perr0)
    );

    multi_channel_scoreboard #(
        .WIDTH(8), .DEPTH(4), .NUM_FIFOS(2), .REARM(1)
    ) d1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .push_sel(push_sel), .pop_sel(pop_sel),
        .data_in(data_in), .data_out(data_out), .start(start),
        .armed(armed1), .done(done1), .data_out_vld(vld1),
        .prop_signal(prop1), .mismatch(mis1), .proto_err(perr1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle afterwards.
    task automatic drive(input logic pu, input logic ps,
                         input logic [7:0] din, input logic st,
                         input logic po, input logic pos,
                         input logic [7:0] dout);
        push = pu; push_sel = ps; data_in = din; start = st;
        pop = po; pop_sel = pos; data_out = dout;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; start = 1'b0;
        push_sel = '0; pop_sel = '0; data_in = '0; data_out = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_vld(input string tag, input logic p);
        exp_t e;
        e.tag = tag;
        e.prop = p;
        exp_q.push_back(e);
    endtask

    // Monitor: every magic exit of the main instance is matched here.
    always @(negedge clk) begin
        if (!rst && vld0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: got vld=1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (prop0 !== e.prop) begin
                    errors++;
                    $display("FAIL %s prop: got %0b expected %0b",
                             e.tag, prop0, e.prop);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();
        chk("rst_armed", armed0, 2'b00);
        chk("rst_done", done0, 2'b00);
        chk("rst_vld", vld0, 1'b0);
        chk("rst_prop", prop0, 1'b1);
        chk("rst_mis", mis0, 1'b0);
        chk("rst_perr", perr0, 1'b0);

        // basic: magic 0x22 behind 0x11
        drive(1, 0, 8'h11, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h22, 1, 0, 0, 8'h00);
        chk("s1_armed", armed0, 2'b01);
        chk("s1_done0", done0, 2'b00);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h11);
        expect_vld("s1_exit", 1'b1);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h22);
        chk("s1_done", done0, 2'b01);
        chk("s1_armed_off", armed0, 2'b00);
        chk("s1_mis", mis0, 1'b0);

        // wrong data on exit
        do_reset();
        drive(1, 0, 8'h11, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h22, 1, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h11);
        chk("s2_mis_before", mis0, 1'b0);
        expect_vld("s2_exit", 1'b0);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h23);
        chk("s2_mis", mis0, 1'b1);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("s2_mis_sticky", mis0, 1'b1);
        chk("s2_perr", perr0, 1'b0);

        // interleave: magic on ch1 while ch0 holds 2
        do_reset();
        drive(1, 0, 8'h01, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h02, 0, 0, 0, 8'h00);
        drive(1, 1, 8'hA0, 1, 0, 0, 8'h00);
        chk("s3_armed", armed0, 2'b10);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h01);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h02);
        chk("s3_armed_hold", armed0, 2'b10);
        expect_vld("s3_exit", 1'b1);
        drive(0, 0, 8'h00, 0, 1, 1, 8'hA0);
        chk("s3_done", done0, 2'b10);

        // capture with same-cycle pop of the only entry ahead
        do_reset();
        drive(1, 0, 8'h33, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h44, 1, 1, 0, 8'h33);
        chk("s4_armed", armed0, 2'b01);
        expect_vld("s4_exit", 1'b1);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h44);
        chk("s4_done", done0, 2'b01);
        chk("s4_perr", perr0, 1'b0);

        // overflow: push into full model is dropped
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 0, 8'(i), 0, 0, 0, 8'h00);
        chk("s5_perr_full", perr0, 1'b0);
        drive(1, 0, 8'hEE, 0, 0, 0, 8'h00);
        chk("s5_perr_ovf", perr0, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 8'h00, 0, 1, 0, 8'(i));
        drive(1, 0, 8'h77, 1, 0, 0, 8'h00);
        chk("s5_armed", armed0, 2'b01);
        expect_vld("s5_exit", 1'b1);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h77);
        chk("s5_done", done0, 2'b01);

        // pop of empty channel
        do_reset();
        drive(0, 0, 8'h00, 0, 1, 1, 8'h00);
        chk("s5_perr_empty", perr0, 1'b1);
        chk("s5_mis_empty", mis0, 1'b0);

        // rearm, then async reset mid-tracking
        do_reset();
        drive(1, 0, 8'h10, 1, 0, 0, 8'h00);
        chk("s6_armed_r1", armed1, 2'b01);
        expect_vld("s6_exit", 1'b1);
        drive(0, 0, 8'h00, 0, 1, 0, 8'h10);
        chk("s6_done_r1", done1, 2'b01);
        chk("s6_done_r0", done0, 2'b01);
        drive(1, 0, 8'h55, 1, 0, 0, 8'h00);
        chk("s6_rearm_r1", armed1, 2'b01);
        chk("s6_rearm_done_r1", done1, 2'b00);
        chk("s6_noarm_r0", armed0, 2'b00);
        chk("s6_stay_done_r0", done0, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_arst_armed", armed1, 2'b00);
        chk("s6_arst_done", done1, 2'b00);
        chk("s6_arst_vld", vld1, 1'b0);
        chk("s6_arst_prop", prop1, 1'b1);
        chk("s6_arst_mis", mis1, 1'b0);
        chk("s6_arst_perr", perr1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
